// File: rtl/cr_clic_ctrl_pkg.sv
// Shared CLIC controller config: FSM encodings, id width, source/ctl-bit counts.
`ifndef CLIC_INTNUM
`define CLIC_INTNUM 80
`endif
`ifndef CLIC_INTCTLBITS
`define CLIC_INTCTLBITS 3
`endif

package cr_clic_ctrl_pkg;
    localparam int CLIC_INTNUM_DEF     = `CLIC_INTNUM;
    localparam int CLIC_INTCTLBITS_DEF = `CLIC_INTCTLBITS;
    localparam int CLIC_ID_WIDTH       = 12;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        CLR  = 2'b10
    } ctrl_state_e;
endpackage

// File: rtl/cr_clic_ctrl_ack_dec.sv
// Registered id-to-onehot decoder; ids outside the source range decode to zero.
module cr_clic_ctrl_ack_dec
    import cr_clic_ctrl_pkg::*;
#(
    parameter int IW  = CLIC_ID_WIDTH,
    parameter int NUM = CLIC_INTNUM_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           valid,
    input  logic [IW-1:0]  id,
    output logic [NUM-1:0] onehot
);
    logic           in_range;
    logic [NUM-1:0] dec;

    assign in_range = int'(id) < NUM;

    always_comb begin
        dec = '0;
        for (int i = 0; i < NUM; i++) begin
            dec[i] = valid && in_range && (id == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot <= '0;
        end else begin
            onehot <= dec;
        end
    end
endmodule

// File: rtl/cr_clic_ctrl_hs.sv
// CLIC arbiter-to-core handshake: qualify, present via req/ack, pulse kid ack.
// Optional CLIC_CTRL_REQ_HOLD_EN locks the presented fields while req is high.
module cr_clic_ctrl_hs
    import cr_clic_ctrl_pkg::*;
#(
    parameter int CLICINTNUM     = CLIC_INTNUM_DEF,
    parameter int CLICINTCTLBITS = CLIC_INTCTLBITS_DEF,
    parameter int ID_WIDTH       = CLIC_ID_WIDTH
) (
    input  logic                      out_clk,
    input  logic                      cpurst_b,
    input  logic                      arb_ctrl_int_hv,
    input  logic [ID_WIDTH-1:0]       arb_ctrl_int_id,
    input  logic [7:0]                arb_ctrl_int_il,
    input  logic                      arb_ctrl_int_mode,
    input  logic                      cpu_clic_mie,
    input  logic [7:0]                cpu_clic_mintthresh,
    input  logic [3:0]                cpu_clic_nlbits,
    input  logic                      cpu_clic_int_ack,
    output logic                      clic_cpu_int_req,
    output logic [ID_WIDTH-1:0]       clic_cpu_int_id,
    output logic [7:0]                clic_cpu_int_il,
    output logic                      clic_cpu_int_hv,
    output logic                      clic_cpu_int_mode,
    output logic [CLICINTNUM-1:0]     ctrl_kid_ack_onehot,
    output logic [CLICINTCTLBITS-1:0] ctrl_xx_int_lv_or_mask
);
`ifdef CLIC_CTRL_REQ_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    ctrl_state_e state;
    logic        cand;
    logic        ack_fire;
    logic        load;
    int          n_lv;

    assign cand = cpu_clic_mie && (arb_ctrl_int_il != 8'd0)
               && (arb_ctrl_int_il > cpu_clic_mintthresh);
    assign ack_fire = (state == REQ) && cpu_clic_int_ack;

    // A pending ack always wins over preemption by a higher candidate.
    assign load = ((state == IDLE) && cand)
               || ((state == REQ) && !HOLD && !cpu_clic_int_ack && cand
                   && (arb_ctrl_int_il > clic_cpu_int_il));

    always_ff @(posedge out_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state             <= IDLE;
            clic_cpu_int_req  <= 1'b0;
            clic_cpu_int_id   <= '0;
            clic_cpu_int_il   <= 8'd0;
            clic_cpu_int_hv   <= 1'b0;
            clic_cpu_int_mode <= 1'b0;
        end else begin
            if (load) begin
                clic_cpu_int_id   <= arb_ctrl_int_id;
                clic_cpu_int_il   <= arb_ctrl_int_il;
                clic_cpu_int_hv   <= arb_ctrl_int_hv;
                clic_cpu_int_mode <= arb_ctrl_int_mode;
            end
            unique case (state)
                IDLE: begin
                    if (cand) begin
                        clic_cpu_int_req <= 1'b1;
                        state            <= REQ;
                    end
                end
                REQ: begin
                    if (cpu_clic_int_ack) begin
                        clic_cpu_int_req <= 1'b0;
                        state            <= CLR;
                    end else if (!cand) begin
                        clic_cpu_int_req <= 1'b0;
                        state            <= IDLE;
                    end
                end
                CLR: state <= IDLE;
                default: begin
                    clic_cpu_int_req <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

    cr_clic_ctrl_ack_dec #(
        .IW  (ID_WIDTH),
        .NUM (CLICINTNUM)
    ) u_ack_dec (
        .clk    (out_clk),
        .rst_n  (cpurst_b),
        .valid  (ack_fire),
        .id     (clic_cpu_int_id),
        .onehot (ctrl_kid_ack_onehot)
    );

    // Unimplemented priority bits below the level field are filled with ones.
    always_comb begin
        n_lv = (int'(cpu_clic_nlbits) < CLICINTCTLBITS)
             ? int'(cpu_clic_nlbits) : CLICINTCTLBITS;
        ctrl_xx_int_lv_or_mask = '0;
        for (int i = 0; i < CLICINTCTLBITS; i++) begin
            ctrl_xx_int_lv_or_mask[i] = (i < CLICINTCTLBITS - n_lv);
        end
    end
endmodule

// File: tb/tb_cr_clic_ctrl_hs.sv
// Self-checking bench for cr_clic_ctrl_hs with an expected-output scoreboard.
module tb_cr_clic_ctrl_hs;
    import cr_clic_ctrl_pkg::*;

`ifdef CLIC_CTRL_REQ_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hv = 1'b0;
    logic [11:0] id = '0;
    logic [7:0]  il = '0;
    logic        mode = 1'b0;
    logic        mie = 1'b0;
    logic [7:0]  thresh = '0;
    logic [3:0]  nlbits = '0;
    logic        ack = 1'b0;
    logic        req;
    logic [11:0] o_id;
    logic [7:0]  o_il;
    logic        o_hv;
    logic        o_mode;
    logic [79:0] onehot;
    logic [2:0]  lv_mask;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        mie;
        logic [7:0]  th;
        logic [7:0]  il;
        logic [11:0] id;
        logic        ack;
        logic        er;
        logic [11:0] eid;
        logic [7:0]  eil;
        int          ebit;
    } step_t;

    typedef struct {
        logic        req;
        logic [11:0] id;
        logic [7:0]  il;
        logic        hv;
        logic        mode;
        logic [79:0] onehot;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cr_clic_ctrl_hs dut (
        .out_clk                (clk),
        .cpurst_b               (rst_n),
        .arb_ctrl_int_hv        (hv),
        .arb_ctrl_int_id        (id),
        .arb_ctrl_int_il        (il),
        .arb_ctrl_int_mode      (mode),
        .cpu_clic_mie           (mie),
        .cpu_clic_mintthresh    (thresh),
        .cpu_clic_nlbits        (nlbits),
        .cpu_clic_int_ack       (ack),
        .clic_cpu_int_req       (req),
        .clic_cpu_int_id        (o_id),
        .clic_cpu_int_il        (o_il),
        .clic_cpu_int_hv        (o_hv),
        .clic_cpu_int_mode      (o_mode),
        .ctrl_kid_ack_onehot    (onehot),
        .ctrl_xx_int_lv_or_mask (lv_mask)
    );

    function automatic step_t mk(logic m, logic [7:0] t, logic [7:0] l,
                                 logic [11:0] i, logic a, logic er,
                                 logic [11:0] eid, logic [7:0] eil, int eb);
        step_t s;
        s.mie = m; s.th = t; s.il = l; s.id = i; s.ack = a;
        s.er = er; s.eid = eid; s.eil = eil; s.ebit = eb;
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one stimulus step and queue the outputs expected after the edge.
    task automatic apply(step_t s);
        exp_t e;
        mie = s.mie; thresh = s.th; il = s.il; id = s.id; ack = s.ack;
        hv = s.id[0]; mode = s.id[1];
        e.req = s.er; e.id = s.eid; e.il = s.eil;
        e.hv = s.eid[0]; e.mode = s.eid[1];
        e.onehot = '0;
        if (s.ebit >= 0) e.onehot[s.ebit] = 1'b1;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick;
        vectors++;
        if (req !== 1'b0 || o_id !== 12'd0 || o_il !== 8'd0 || o_hv !== 1'b0
            || o_mode !== 1'b0 || onehot !== 80'd0) begin
            miscompares++;
            $display("FAIL reset: req=%b id=%0d il=%h hv=%b mode=%b onehot=%h, want all 0",
                     req, o_id, o_il, o_hv, o_mode, onehot);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 8'h00, 8'hBF, 12'd17, 0, 1, 12'd17, 8'hBF, -1));
        st.push_back(mk(1, 8'h00, 8'hBF, 12'd17, 1, 0, 12'd17, 8'hBF, 17));
        st.push_back(mk(1, 8'h00, 8'h00, 12'd0, 0, 0, 12'd17, 8'hBF, -1));
        st.push_back(mk(1, 8'h00, 8'h00, 12'd0, 0, 0, 12'd17, 8'hBF, -1));
        foreach (st[k]) begin
            apply(st[k]);
            tick;
            e = sb.pop_front();
            vectors++;
            if (req !== e.req || onehot !== e.onehot || (e.req && (o_id !== e.id
                || o_il !== e.il || o_hv !== e.hv || o_mode !== e.mode))) begin
                miscompares++;
                $display("FAIL basic[%0d]: req=%b id=%0d il=%h onehot=%h, want req=%b id=%0d il=%h onehot=%h",
                         k, req, o_id, o_il, onehot, e.req, e.id, e.il, e.onehot);
            end
        end
    endtask

    task automatic test_threshold;
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 8'hBF, 8'hBF, 12'd5, 0, 0, 12'd0, 8'h00, -1));
        st.push_back(mk(1, 8'hBF, 8'hBF, 12'd5, 0, 0, 12'd0, 8'h00, -1));
        st.push_back(mk(1, 8'hBF, 8'hDF, 12'd5, 0, 1, 12'd5, 8'hDF, -1));
        st.push_back(mk(1, 8'hBF, 8'hDF, 12'd5, 1, 0, 12'd5, 8'hDF, 5));
        st.push_back(mk(1, 8'hBF, 8'h00, 12'd0, 0, 0, 12'd5, 8'hDF, -1));
        foreach (st[k]) begin
            apply(st[k]);
            tick;
            e = sb.pop_front();
            vectors++;
            if (req !== e.req || onehot !== e.onehot || (e.req && (o_id !== e.id
                || o_il !== e.il || o_hv !== e.hv || o_mode !== e.mode))) begin
                miscompares++;
                $display("FAIL threshold[%0d]: req=%b id=%0d il=%h onehot=%h, want req=%b id=%0d il=%h onehot=%h",
                         k, req, o_id, o_il, onehot, e.req, e.id, e.il, e.onehot);
            end
        end
    endtask

    task automatic test_preempt;
        step_t       st[$];
        exp_t        e;
        logic [11:0] pid;
        logic [7:0]  pil;
        pid = HOLD ? 12'd17 : 12'd40;
        pil = HOLD ? 8'h9F : 8'hFF;
        st.push_back(mk(1, 8'h00, 8'h9F, 12'd17, 0, 1, 12'd17, 8'h9F, -1));
        st.push_back(mk(1, 8'h00, 8'hFF, 12'd40, 0, 1, pid, pil, -1));
        st.push_back(mk(1, 8'h00, 8'hFF, 12'd50, 0, 1, pid, pil, -1));
        st.push_back(mk(1, 8'h00, 8'hA0, 12'd60, 0, 1, pid, pil, -1));
        st.push_back(mk(1, 8'h00, 8'hA0, 12'd60, 1, 0, pid, pil, int'(pid)));
        st.push_back(mk(1, 8'h00, 8'h00, 12'd0, 0, 0, pid, pil, -1));
        st.push_back(mk(1, 8'h00, 8'h00, 12'd0, 0, 0, pid, pil, -1));
        foreach (st[k]) begin
            apply(st[k]);
            tick;
            e = sb.pop_front();
            vectors++;
            if (req !== e.req || onehot !== e.onehot || (e.req && (o_id !== e.id
                || o_il !== e.il || o_hv !== e.hv || o_mode !== e.mode))) begin
                miscompares++;
                $display("FAIL preempt[%0d]: req=%b id=%0d il=%h onehot=%h, want req=%b id=%0d il=%h onehot=%h",
                         k, req, o_id, o_il, onehot, e.req, e.id, e.il, e.onehot);
            end
        end
    endtask

    task automatic test_back_to_back;
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 8'h00, 8'h9F, 12'd17, 0, 1, 12'd17, 8'h9F, -1));
        st.push_back(mk(1, 8'h00, 8'hFF, 12'd40, 1, 0, 12'd17, 8'h9F, 17));
        st.push_back(mk(1, 8'h00, 8'hFF, 12'd40, 0, 0, 12'd17, 8'h9F, -1));
        st.push_back(mk(1, 8'h00, 8'hFF, 12'd40, 0, 1, 12'd40, 8'hFF, -1));
        st.push_back(mk(1, 8'h00, 8'h00, 12'd0, 1, 0, 12'd40, 8'hFF, 40));
        st.push_back(mk(1, 8'h00, 8'h00, 12'd0, 0, 0, 12'd40, 8'hFF, -1));
        st.push_back(mk(1, 8'h00, 8'h00, 12'd0, 0, 0, 12'd40, 8'hFF, -1));
        foreach (st[k]) begin
            apply(st[k]);
            tick;
            e = sb.pop_front();
            vectors++;
            if (req !== e.req || onehot !== e.onehot || (e.req && (o_id !== e.id
                || o_il !== e.il || o_hv !== e.hv || o_mode !== e.mode))) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: req=%b id=%0d il=%h onehot=%h, want req=%b id=%0d il=%h onehot=%h",
                         k, req, o_id, o_il, onehot, e.req, e.id, e.il, e.onehot);
            end
        end
    endtask

    task automatic test_withdraw;
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 8'h00, 8'h9F, 12'd17, 0, 1, 12'd17, 8'h9F, -1));
        st.push_back(mk(0, 8'h00, 8'h9F, 12'd17, 0, 0, 12'd17, 8'h9F, -1));
        st.push_back(mk(0, 8'h00, 8'h9F, 12'd17, 1, 0, 12'd17, 8'h9F, -1));
        st.push_back(mk(0, 8'h00, 8'h9F, 12'd17, 0, 0, 12'd17, 8'h9F, -1));
        st.push_back(mk(1, 8'h00, 8'h9F, 12'd18, 0, 1, 12'd18, 8'h9F, -1));
        st.push_back(mk(1, 8'hFF, 8'h9F, 12'd18, 0, 0, 12'd18, 8'h9F, -1));
        st.push_back(mk(1, 8'hFF, 8'h9F, 12'd18, 0, 0, 12'd18, 8'h9F, -1));
        foreach (st[k]) begin
            apply(st[k]);
            tick;
            e = sb.pop_front();
            vectors++;
            if (req !== e.req || onehot !== e.onehot || (e.req && (o_id !== e.id
                || o_il !== e.il || o_hv !== e.hv || o_mode !== e.mode))) begin
                miscompares++;
                $display("FAIL withdraw[%0d]: req=%b id=%0d il=%h onehot=%h, want req=%b id=%0d il=%h onehot=%h",
                         k, req, o_id, o_il, onehot, e.req, e.id, e.il, e.onehot);
            end
        end
    endtask

    task automatic test_id_range;
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 8'h00, 8'h9F, 12'd100, 0, 1, 12'd100, 8'h9F, -1));
        st.push_back(mk(1, 8'h00, 8'h9F, 12'd100, 1, 0, 12'd100, 8'h9F, -1));
        st.push_back(mk(1, 8'h00, 8'h00, 12'd0, 0, 0, 12'd100, 8'h9F, -1));
        st.push_back(mk(1, 8'h00, 8'h9F, 12'd79, 0, 1, 12'd79, 8'h9F, -1));
        st.push_back(mk(1, 8'h00, 8'h9F, 12'd79, 1, 0, 12'd79, 8'h9F, 79));
        st.push_back(mk(1, 8'h00, 8'h00, 12'd0, 0, 0, 12'd79, 8'h9F, -1));
        foreach (st[k]) begin
            apply(st[k]);
            tick;
            e = sb.pop_front();
            vectors++;
            if (req !== e.req || onehot !== e.onehot || (e.req && (o_id !== e.id
                || o_il !== e.il || o_hv !== e.hv || o_mode !== e.mode))) begin
                miscompares++;
                $display("FAIL id_range[%0d]: req=%b id=%0d il=%h onehot=%h, want req=%b id=%0d il=%h onehot=%h",
                         k, req, o_id, o_il, onehot, e.req, e.id, e.il, e.onehot);
            end
        end
    endtask

    task automatic test_lv_mask;
        logic [3:0] nl[5];
        logic [2:0] want[5];
        nl = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd15};
        want = '{3'b111, 3'b011, 3'b001, 3'b000, 3'b000};
        foreach (nl[k]) begin
            nlbits = nl[k];
            #1;
            vectors++;
            if (lv_mask !== want[k]) begin
                miscompares++;
                $display("FAIL lv_mask nlbits=%0d: got %b want %b", nl[k], lv_mask, want[k]);
            end
        end
        nlbits = 4'd0;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        apply(mk(1, 8'h00, 8'hC0, 12'd33, 0, 1, 12'd33, 8'hC0, -1));
        tick;
        e = sb.pop_front();
        vectors++;
        if (req !== e.req || o_id !== e.id || o_il !== e.il) begin
            miscompares++;
            $display("FAIL reset_mid setup: req=%b id=%0d il=%h, want req=1 id=33 il=c0",
                     req, o_id, o_il);
        end
        #2;
        ack = 1'b1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (req !== 1'b0 || o_id !== 12'd0 || o_il !== 8'd0 || o_hv !== 1'b0
            || o_mode !== 1'b0 || onehot !== 80'd0) begin
            miscompares++;
            $display("FAIL reset_mid: req=%b id=%0d il=%h onehot=%h, want all 0",
                     req, o_id, o_il, onehot);
        end
        tick;
        vectors++;
        if (req !== 1'b0 || onehot !== 80'd0) begin
            miscompares++;
            $display("FAIL reset_mid hold: req=%b onehot=%h, want 0", req, onehot);
        end
        ack = 1'b0;
        il = 8'd0;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_threshold;
        test_preempt;
        test_back_to_back;
        test_withdraw;
        test_id_range;
        test_lv_mask;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, want finish before 100000");
        $fatal(1);
    end
endmodule
